npu_load_sequencer: RTL

Avalon-MM slave controller that sequences NPU initialisation and run. It steers host payload writes into the image RAMs, conv weight RAM and dense weight RAMs, tracks load progress, and starts the NPU. It reports status and raises an interrupt on completion. It replaces free-running write counters with per-transaction, write-strobe-gated sequencing.

---
 rtl/npu_load_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/npu_load_sequencer.sv
// Avalon-MM load/run sequencer for the NPU: steers DATA writes into image,
// conv and dense RAMs in order, starts the NPU and reports status/irq.
module npu_load_sequencer #(
    parameter int IMG_WORDS   = 225,
    parameter int CONV_BYTES  = 18816,
    parameter int DENSE_WORDS = 4204
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] wdata,
    output logic        we_image,
    output logic [9:0]  image_addr,
    output logic        we_conv,
    output logic [14:0] conv_addr,
    output logic        we_dense,
    output logic [14:0] dense_addr,
    output logic        npu_start,
    input  logic        npu_done,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_IMG   = 3'd1,
        S_LOAD_CONV  = 3'd2,
        S_LOAD_DENSE = 3'd3,
        S_LOADED     = 3'd4,
        S_RUN        = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [14:0] r_idx;
    logic [15:0] r_count;
    logic        r_err_data;
    logic        r_err_cmd;

    logic w_wr, w_rd, w_ctrl_wr, w_data_wr;
    logic w_abort, w_start, w_run, w_in_load, w_accept, w_last;
    logic w_start_ok, w_run_ok, w_cmd_err, w_done_evt;
    logic [31:0] w_status;

    assign w_wr      = chipselect & write;
    assign w_rd      = chipselect & read;
    assign w_ctrl_wr = w_wr && (address == 2'd0);
    assign w_data_wr = w_wr && (address == 2'd1);
    // ABORT masks the other command bits of the same CTRL write
    assign w_abort   = w_ctrl_wr & writedata[1];
    assign w_start   = w_ctrl_wr & ~writedata[1] & writedata[0];
    assign w_run     = w_ctrl_wr & ~writedata[1] & writedata[2];
    assign w_in_load = (r_state == S_LOAD_IMG) || (r_state == S_LOAD_CONV) ||
                       (r_state == S_LOAD_DENSE);
    assign w_accept  = w_data_wr & w_in_load;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_LOAD_IMG:   w_last = (r_idx == 15'(IMG_WORDS - 1));
            S_LOAD_CONV:  w_last = (r_idx == 15'(CONV_BYTES - 1));
            S_LOAD_DENSE: w_last = (r_idx == 15'(DENSE_WORDS - 1));
            default:      w_last = 1'b0;
        endcase
    end

    assign w_start_ok = w_start && ((r_state == S_IDLE) || (r_state == S_LOADED) ||
                                    (r_state == S_DONE));
    assign w_run_ok   = w_run && !w_start && ((r_state == S_LOADED) || (r_state == S_DONE));
    assign w_cmd_err  = (w_start && !w_start_ok) || (w_run && !w_start && !w_run_ok);
    assign w_done_evt = (r_state == S_RUN) && npu_done && !w_abort;

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else if (w_start_ok) begin
            w_next_state = S_LOAD_IMG;
        end else if (w_run_ok) begin
            w_next_state = S_RUN;
        end else if (w_accept && w_last) begin
            case (r_state)
                S_LOAD_IMG:  w_next_state = S_LOAD_CONV;
                S_LOAD_CONV: w_next_state = S_LOAD_DENSE;
                default:     w_next_state = S_LOADED;
            endcase
        end else if (w_done_evt) begin
            w_next_state = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    assign w_status = {23'd0, irq, 2'd0, r_err_cmd, r_err_data, 1'b0, r_state};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_count    <= '0;
            r_err_data <= 1'b0;
            r_err_cmd  <= 1'b0;
            irq        <= 1'b0;
            npu_start  <= 1'b0;
            we_image   <= 1'b0;
            we_conv    <= 1'b0;
            we_dense   <= 1'b0;
            image_addr <= '0;
            conv_addr  <= '0;
            dense_addr <= '0;
            wdata      <= '0;
            readdata   <= '0;
        end else begin
            we_image  <= 1'b0;
            we_conv   <= 1'b0;
            we_dense  <= 1'b0;
            npu_start <= w_run_ok;

            if (w_abort) begin
                r_idx      <= '0;
                r_err_data <= 1'b0;
                r_err_cmd  <= 1'b0;
            end else if (w_start_ok) begin
                r_idx      <= '0;
                r_count    <= '0;
                r_err_data <= 1'b0;
                r_err_cmd  <= 1'b0;
            end else begin
                if (w_cmd_err)               r_err_cmd  <= 1'b1;
                if (w_data_wr && !w_in_load) r_err_data <= 1'b1;
                if (w_accept) begin
                    wdata   <= writedata;
                    r_count <= r_count + 16'd1;
                    r_idx   <= w_last ? 15'd0 : r_idx + 15'd1;
                    case (r_state)
                        S_LOAD_IMG: begin
                            we_image   <= 1'b1;
                            image_addr <= r_idx[9:0];
                        end
                        S_LOAD_CONV: begin
                            we_conv   <= 1'b1;
                            conv_addr <= r_idx;
                        end
                        default: begin
                            we_dense   <= 1'b1;
                            dense_addr <= r_idx;
                        end
                    endcase
                end
            end

            // completion outranks the STATUS-read clear in the same cycle
            if (w_abort)                          irq <= 1'b0;
            else if (w_done_evt)                  irq <= 1'b1;
            else if (w_rd && (address == 2'd2))   irq <= 1'b0;

            if (w_rd) begin
                case (address)
                    2'd2:    readdata <= w_status;
                    2'd3:    readdata <= {16'd0, r_count};
                    default: readdata <= '0;
                endcase
            end
        end
    end

endmodule
